// File: rtl/rng_prefetch_fifo.sv
// Prefetch FIFO between simplerng and the iomem bus: a fill FSM keeps up to 2**DEPTH_LOG2 words ready.
// Bus accesses always ack one cycle after acceptance; RNG stalls only slow the refill, never the bus.
`timescale 1ns/1ps
module rng_prefetch_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned THRESH     = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  bus_valid,
  output logic                  bus_ready,
  input  logic [3:0]            bus_wstrb,
  input  logic [3:0]            bus_addr,
  input  logic [31:0]           bus_wdata,
  output logic [31:0]           bus_rdata,
  output logic                  rng_dat_re,
  output logic                  rng_dat_we,
  output logic [31:0]           rng_dat_di,
  input  logic [31:0]           rng_dat_do,
  input  logic                  rng_dat_wait,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  irq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_C  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   THRESH_C = (DEPTH_LOG2 + 1)'(THRESH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);
  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_SEED   = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_GAP} fill_state_e;

  fill_state_e              state_q;
  logic [31:0]              mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]      count_q, count_d;
  logic                     underflow_q, underflow_d;
  logic                     ready_q;
  logic [31:0]              rdata_q, rdata_d;
  logic                     re_q;
  logic                     we_q;
  logic [31:0]              di_q;
  logic                     irq_q;

  logic                     accept, is_wr, seed_wr, data_rd;
  logic                     empty, full, push, pop;
  logic [1:0]               reg_sel;
  logic [31:0]              seed_data;
  logic                     unused_addr;

  assign unused_addr = ^bus_addr[1:0];

  assign accept  = bus_valid && !ready_q;
  assign is_wr   = |bus_wstrb;
  assign reg_sel = bus_addr[3:2];
  assign seed_wr = accept && is_wr && (reg_sel == A_SEED);
  assign data_rd = accept && !is_wr && (reg_sel == A_DATA);
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign pop     = data_rd && !empty;
  // A seed write flushes the FIFO, so it also swallows a word landing on the same edge.
  assign push    = (state_q == S_FETCH) && !seed_wr;

  always_comb begin
    seed_data = '0;
    for (int b = 0; b < 4; b++) begin
      if (bus_wstrb[b]) seed_data[8*b +: 8] = bus_wdata[8*b +: 8];
    end
  end

  always_comb begin
    rdata_d     = '0;
    underflow_d = underflow_q;
    if (accept && !is_wr) begin
      case (reg_sel)
        A_DATA: begin
          if (empty) begin
            rdata_d     = '1;
            underflow_d = 1'b1;
          end else begin
            rdata_d = mem_q[rd_ptr_q];
          end
        end
        A_STATUS: begin
          rdata_d     = {21'b0, underflow_q, full, empty, 8'(count_q)};
          underflow_d = 1'b0;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (seed_wr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  // Fill FSM: IDLE decides, FETCH strobes the RNG and captures, GAP lets rng_dat_wait settle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      re_q    <= 1'b0;
    end else begin
      re_q <= 1'b0;
      if (seed_wr) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!full && !rng_dat_wait) begin
              state_q <= S_FETCH;
              re_q    <= 1'b1;
            end
          end
          S_FETCH: state_q <= S_GAP;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push) mem_q[wr_ptr_q] <= rng_dat_do;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      di_q        <= '0;
      irq_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      ready_q     <= accept;
      rdata_q     <= rdata_d;
      we_q        <= seed_wr;
      if (seed_wr) di_q <= seed_data;
      irq_q       <= (count_d >= THRESH_C);
    end
  end

  assign bus_ready  = ready_q;
  assign bus_rdata  = rdata_q;
  assign rng_dat_re = re_q;
  assign rng_dat_we = we_q;
  assign rng_dat_di = di_q;
  assign fifo_count = count_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_rng_prefetch_fifo.sv
// Directed scenarios then random traffic against a queue-based reference of the prefetch buffer.
`timescale 1ns/1ps
module tb_rng_prefetch_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        bus_valid;
  logic        bus_ready;
  logic [3:0]  bus_wstrb;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        rng_dat_re;
  logic        rng_dat_we;
  logic [31:0] rng_dat_di;
  logic [31:0] rng_word;
  logic        rng_dat_wait;
  logic [3:0]  fifo_count;
  logic        irq;

  always #5 clk = ~clk;

  rng_prefetch_fifo #(.DEPTH_LOG2(3), .THRESH(4)) dut (
    .clk(clk), .resetn(resetn),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .rng_dat_re(rng_dat_re), .rng_dat_we(rng_dat_we), .rng_dat_di(rng_dat_di),
    .rng_dat_do(rng_word), .rng_dat_wait(rng_dat_wait),
    .fifo_count(fifo_count), .irq(irq)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: FIFO contents as a queue plus the externally visible registers.
  logic [31:0] m_q[$];
  bit          m_uf = 0, m_rdy = 0, m_we = 0, m_fetch = 0;
  int          m_hold = 0;
  logic [31:0] m_rdata = 0, m_di = 0, rng_next = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strb_mask(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Applies the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    int   n = m_q.size();
    bit   acc, wr, seed;
    logic [1:0] a;
    rng_next = rng_word;
    if (!resetn) begin
      m_q.delete();
      m_uf = 0; m_rdy = 0; m_we = 0; m_fetch = 0; m_hold = 0;
      m_rdata = 0; m_di = 0;
      return;
    end
    acc  = bus_valid && !m_rdy;
    wr   = |bus_wstrb;
    a    = bus_addr[3:2];
    seed = acc && wr && (a == 2'd2);
    m_rdy = acc; m_we = 0; m_rdata = 0;
    if (acc && !wr) begin
      if (a == 2'd0) begin
        if (n == 0) begin m_rdata = 32'hFFFF_FFFF; m_uf = 1; end
        else m_rdata = m_q.pop_front();
      end else if (a == 2'd1) begin
        m_rdata = {21'b0, m_uf, (n == 8), (n == 0), 8'(n)};
        m_uf = 0;
      end
    end
    if (seed) begin
      m_we = 1; m_di = strb_mask(bus_wdata, bus_wstrb);
      m_q.delete(); m_fetch = 0; m_hold = 0;
      rng_next = m_di;
    end else if (m_fetch) begin
      m_q.push_back(rng_word);
      rng_next = rng_word + 1;
      m_fetch = 0; m_hold = 1;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (n < 8 && !rng_dat_wait) begin
      m_fetch = 1;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    rng_word = rng_next;
    chk("ready", 32'(bus_ready), 32'(m_rdy));
    if (m_rdy) chk("rdata", bus_rdata, m_rdata);
    chk("rng_re", 32'(rng_dat_re), 32'(m_fetch));
    chk("rng_we", 32'(rng_dat_we), 32'(m_we));
    chk("rng_di", rng_dat_di, m_di);
    chk("count", 32'(fifo_count), 32'(m_q.size()));
    chk("irq", 32'(irq), 32'(m_q.size() >= 4));
  endtask

  task automatic bus_op(input logic [3:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, output logic [31:0] rd);
    bus_valid = 1; bus_addr = addr; bus_wstrb = strb; bus_wdata = wd;
    cycle();
    chk("ack", 32'(bus_ready), 32'd1);
    rd = bus_rdata;
    bus_valid = 0; bus_wstrb = 0;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    resetn = 0; bus_valid = 0; bus_wstrb = 0; bus_addr = 0; bus_wdata = 0;
    rng_dat_wait = 0; rng_word = 32'd1;
    cycle(); cycle();
    chk("rst_ready", 32'(bus_ready), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_re", 32'(rng_dat_re), 32'd0);
    chk("rst_di", rng_dat_di, 32'd0);

    // Fill from empty at one word per three cycles.
    resetn = 1;
    repeat (24) cycle();
    chk("t1_count", 32'(fifo_count), 32'd8);
    chk("t1_irq", 32'(irq), 32'd1);
    repeat (6) cycle();
    rng_dat_wait = 1;
    bus_op(4'h4, 4'h0, 0, rd);
    chk("t1_status", rd, 32'h0000_0208);

    // Drain in order, then underflow and its sticky clear-on-read flag.
    for (int i = 1; i <= 8; i++) begin
      bus_op(4'h0, 4'h0, 0, rd);
      chk("t2_data", rd, 32'(i));
    end
    bus_op(4'h0, 4'h0, 0, rd);
    chk("t2_empty_read", rd, 32'hFFFF_FFFF);
    bus_op(4'h4, 4'h0, 0, rd);
    chk("t2_status_uf", rd, 32'h0000_0500);
    bus_op(4'h4, 4'h0, 0, rd);
    chk("t2_status_clr", rd, 32'h0000_0100);

    // Seed write with partial strobes flushes a partly filled FIFO.
    rng_dat_wait = 0;
    repeat (9) cycle();
    rng_dat_wait = 1;
    bus_valid = 1; bus_addr = 4'h8; bus_wstrb = 4'b0011; bus_wdata = 32'hA5A5_1234;
    cycle();
    chk("t3_we", 32'(rng_dat_we), 32'd1);
    chk("t3_di", rng_dat_di, 32'h0000_1234);
    chk("t3_count", 32'(fifo_count), 32'd0);
    bus_valid = 0; bus_wstrb = 0;
    cycle();
    chk("t3_we_off", 32'(rng_dat_we), 32'd0);

    // Pop coinciding with a fetch capture at count 4.
    rng_dat_wait = 0;
    for (int k = 0; k < 200 && !(fifo_count == 4 && rng_dat_re); k++) cycle();
    chk("t4_reach", 32'(fifo_count == 4 && rng_dat_re), 32'd1);
    bus_valid = 1; bus_addr = 4'h0; bus_wstrb = 0;
    cycle();
    rd = bus_rdata;
    bus_valid = 0; rng_dat_wait = 1;
    chk("t4_head", rd, 32'h0000_1234);
    chk("t4_count", 32'(fifo_count), 32'd4);
    cycle();
    for (int k = 0; k < 4; k++) begin
      bus_op(4'h0, 4'h0, 0, rd);
      chk("t4_order", rd, 32'h0000_1235 + 32'(k));
    end

    // RNG stalled from empty: no fetch strobes.
    repeat (20) cycle();
    chk("t5_count", 32'(fifo_count), 32'd0);
    chk("t5_irq", 32'(irq), 32'd0);

    // Reset on the acceptance edge of a read at count 5.
    rng_dat_wait = 0;
    for (int k = 0; k < 200 && fifo_count != 5; k++) cycle();
    chk("t6_reach", 32'(fifo_count), 32'd5);
    rng_dat_wait = 1;
    bus_valid = 1; bus_addr = 4'h0; bus_wstrb = 0; resetn = 0;
    cycle();
    bus_valid = 0;
    chk("t6_ready", 32'(bus_ready), 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_di", rng_dat_di, 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    resetn = 1;
    cycle();
    chk("t6_ready_after", 32'(bus_ready), 32'd0);

    // Random traffic.
    repeat (3000) begin
      resetn       = ($urandom_range(0, 299) != 0);
      bus_valid    = 1'($urandom_range(0, 1));
      bus_addr     = 4'($urandom);
      bus_wstrb    = ($urandom_range(0, 9) < 6) ? 4'b0000 : 4'($urandom);
      bus_wdata    = $urandom;
      rng_dat_wait = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
